// File: rtl/psub_seq_pkg.sv
// Shared types and constants for the sequential saturating add/sub engine.
package psub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LANE_W    = 4;
    localparam int NUM_LANES = 4;

    localparam logic [3:0]  SAT_POS4  = 4'h7;
    localparam logic [3:0]  SAT_NEG4  = 4'h8;
    localparam logic [15:0] SAT_POS16 = 16'h7FFF;
    localparam logic [15:0] SAT_NEG16 = 16'h8000;

    typedef struct packed {
        logic        sub;
        logic        pad;
        logic [15:0] a;
        logic [15:0] b;
    } op_t;

endpackage

// File: rtl/psub_seq_lane_addsub.sv
// One 4-bit lane of the add/sub datapath: raw sum, carry-out and
// signed overflow computed against the effective (possibly inverted) B.
module lane_addsub
    import psub_seq_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              sub,
    input  logic              cin,
    output logic [LANE_W-1:0] sum,
    output logic              cout,
    output logic              lane_ovfl
);

    logic [LANE_W-1:0] eb;
    logic [LANE_W:0]   full;

    always_comb begin
        eb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, eb} + {{LANE_W{1'b0}}, cin};
        sum  = full[LANE_W-1:0];
        cout = full[LANE_W];
        lane_ovfl = (a[LANE_W-1] == eb[LANE_W-1]) &&
                    (sum[LANE_W-1] != a[LANE_W-1]);
    end

endmodule

// File: rtl/psub_seq.sv
// Multi-cycle saturating add/sub: one 4-bit lane per clock, full-width
// or per-lane saturation, start/done handshake with the execute stage.
module psub_seq
    import psub_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANE  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             pad,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovfl
);

    state_t            state;
    state_t            state_nx;
    op_t               op;
    logic [1:0]        idx;
    logic              carry_reg;
    logic [WIDTH-1:0]  acc;
    logic              ovfl_acc;

    logic [LANE-1:0]   a_lane;
    logic [LANE-1:0]   b_lane;
    logic              cin;
    logic [LANE-1:0]   sum;
    logic              cout;
    logic              lane_ovfl;
    logic [LANE-1:0]   lane_val;
    logic [WIDTH-1:0]  final_res;
    logic              final_ovfl;
    logic              last_lane;

    always_comb begin
        a_lane = op.a[int'(idx)*LANE +: LANE];
        b_lane = op.b[int'(idx)*LANE +: LANE];
        cin    = op.pad ? op.sub : carry_reg;
    end

    lane_addsub u_lane (
        .a         (a_lane),
        .b         (b_lane),
        .sub       (op.sub),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .lane_ovfl (lane_ovfl)
    );

    // Saturation direction follows the sign of the A operand.
    always_comb begin
        last_lane = (idx == 2'(NUM_LANES - 1));
        lane_val  = sum;
        if (op.pad && lane_ovfl) begin
            lane_val = a_lane[LANE-1] ? SAT_NEG4 : SAT_POS4;
        end
        final_res  = {lane_val, acc[WIDTH-LANE-1:0]};
        final_ovfl = lane_ovfl;
        if (op.pad) begin
            final_ovfl = ovfl_acc | lane_ovfl;
        end else if (lane_ovfl) begin
            final_res = op.a[WIDTH-1] ? SAT_NEG16 : SAT_POS16;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_lane) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= '0;
            idx       <= '0;
            carry_reg <= 1'b0;
            acc       <= '0;
            ovfl_acc  <= 1'b0;
            result    <= '0;
            ovfl      <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op        <= '{sub: sub, pad: pad, a: A, b: B};
                        idx       <= '0;
                        carry_reg <= sub;
                        acc       <= '0;
                        ovfl_acc  <= 1'b0;
                    end
                end
                RUN: begin
                    acc[int'(idx)*LANE +: LANE] <= lane_val;
                    carry_reg <= cout;
                    ovfl_acc  <= ovfl_acc | (op.pad & lane_ovfl);
                    idx       <= idx + 2'd1;
                    if (last_lane) begin
                        result <= final_res;
                        ovfl   <= final_ovfl;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_psub_seq.sv
// Directed self-checking bench for psub_seq.
`timescale 1ns/1ps
module tb_psub_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic        pad;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        ovfl;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    psub_seq #(.WIDTH(16), .LANE(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .pad    (pad),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovfl   (ovfl)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic p,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic eo);
        int lat;
        @(negedge clk);
        start = 1'b1; sub = s; pad = p; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; sub = ~s; pad = ~p; A = ~a; B = 16'h5A5A;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, 32'd5);
        chk({tag, "_res"}, {16'd0, result}, {16'd0, er});
        chk({tag, "_ovf"}, {31'd0, ovfl}, {31'd0, eo});
        @(posedge clk); #1;
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_hold"}, {16'd0, result}, {16'd0, er});
    endtask

    initial begin
        int ndone;
        logic [15:0] seen;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; pad = 1'b0;
        A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_res", {16'd0, result}, 32'd0);
        chk("rst_ovf", {31'd0, ovfl}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op("add16_sat", 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1);
        run_op("sub16", 1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0);
        run_op("sub16_sat", 1'b1, 1'b0, 16'h8000, 16'h0001, 16'h8000, 1'b1);
        run_op("add16", 1'b0, 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0);
        run_op("add4", 1'b0, 1'b1, 16'h7189, 16'h1F99, 16'h7088, 1'b1);
        run_op("sub4_sat", 1'b1, 1'b1, 16'h0000, 16'h8888, 16'h7777, 1'b1);
        run_op("sub4", 1'b1, 1'b1, 16'h3333, 16'h1111, 16'h2222, 1'b0);

        // second start two cycles into a run must be dropped
        @(negedge clk);
        start = 1'b1; sub = 1'b0; pad = 1'b0; A = 16'h1234; B = 16'h1111;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        start = 1'b1; sub = 1'b1; pad = 1'b1; A = 16'hFFFF; B = 16'h0F0F;
        @(posedge clk); #1; start = 1'b0;
        ndone = 0; seen = '0;
        repeat (10) begin
            if (done) begin ndone++; seen = result; end
            @(posedge clk); #1;
        end
        chk("ign_ndone", ndone, 32'd1);
        chk("ign_res", {16'd0, seen}, 32'h2345);

        // reset during lane 2
        @(negedge clk);
        start = 1'b1; sub = 1'b0; pad = 1'b0; A = 16'h1111; B = 16'h2222;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_res", {16'd0, result}, 32'd0);
        chk("mrst_ovf", {31'd0, ovfl}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_op("post_rst", 1'b0, 1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
